// File: rtl/cmd_assembler.sv
// Assembles {high, low} command words from a byte stream with an inter-byte timeout.
// Define CMD_CHKSUM_EN to require a trailing checksum byte ~(hi + lo) on each frame.
module cmd_assembler #(
  parameter int unsigned TIMEOUT = 10800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [7:0]  byte_in,
  output logic        clr_rdy,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    WAIT_HI  = 2'd0,
`ifdef CMD_CHKSUM_EN
    WAIT_CHK = 2'd2,
`endif
    WAIT_LO  = 2'd1
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        err_q, err_d;
  logic [15:0] tmo_q, tmo_d;

`ifdef CMD_CHKSUM_EN
  logic [7:0] chk_sum;
  assign chk_sum = hi_q + lo_q;
`endif

  // Every byte is accepted in the cycle it is presented, whatever the state.
  assign clr_rdy   = rdy;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    err_d     = 1'b0;
    tmo_d     = tmo_q;

    // A completion later in this block overrides the acknowledge.
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;

    case (state_q)
      WAIT_HI: begin
        tmo_d = '0;
        if (rdy) begin
          hi_d    = byte_in;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (rdy) begin
          lo_d  = byte_in;
          tmo_d = '0;
`ifdef CMD_CHKSUM_EN
          state_d = WAIT_CHK;
`else
          cmd_d     = {hi_q, byte_in};
          cmd_rdy_d = 1'b1;
          state_d   = WAIT_HI;
`endif
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_HI;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
`ifdef CMD_CHKSUM_EN
      WAIT_CHK: begin
        if (rdy) begin
          tmo_d   = '0;
          state_d = WAIT_HI;
          if (byte_in == ~chk_sum) begin
            cmd_d     = {hi_q, lo_q};
            cmd_rdy_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_HI;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
`endif
      default: begin
        tmo_d   = '0;
        state_d = WAIT_HI;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_HI;
      hi_q      <= '0;
      lo_q      <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_cmd_assembler.sv
// Directed self-checking bench for cmd_assembler; expected commands flow through exp_q.
module tb_cmd_assembler;

  localparam int TMO = 1500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [7:0]  byte_in;
  logic        clr_rdy;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int accept_cnt = 0;
  int bytes_sent = 0;
  int err_cnt = 0;
  logic [15:0] exp_q[$];

  cmd_assembler #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .byte_in(byte_in), .clr_rdy(clr_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // monitors
  always @(posedge clk) if (rst_n && clr_rdy) accept_cnt++;
  always @(negedge clk) if (rst_n && err) err_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver model: rdy stays up (at most hold cycles) until clr_rdy is seen at an edge.
  // Returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int hold, input logic ack);
    logic c;
    @(negedge clk);
    rdy = 1'b1;
    byte_in = b;
    clr_cmd_rdy = ack;
    bytes_sent++;
    for (int i = 0; i < hold; i++) begin
      #1 c = clr_rdy;
      @(posedge clk);
      #1;
      clr_cmd_rdy = 1'b0;
      if (c) break;
      @(negedge clk);
    end
    rdy = 1'b0;
    byte_in = 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic ack);
    logic [7:0] s;
    s = hi + lo;
    exp_q.push_back({hi, lo});
    send_byte(hi, 3, 1'b0);
`ifdef CMD_CHKSUM_EN
    send_byte(lo, 3, 1'b0);
    send_byte(~s, 3, ack);
`else
    send_byte(lo, 3, ack);
`endif
  endtask

  task automatic check_cmd(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_cmd"}, 32'(cmd), 32'(e));
      check({tag, "_cmd_rdy"}, 32'(cmd_rdy), 32'd1);
    end
  endtask

  initial begin
    int acc0;
    int err0;
    rst_n = 1'b0;
    rdy = 1'b1;
    byte_in = 8'h00;
    clr_cmd_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clr_rdy_follows", 32'(clr_rdy), 32'd1);
    rdy = 1'b0;
    #1;
    check("rst_clr_rdy_low", 32'(clr_rdy), 32'd0);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // A5, 1200-cycle gap, 3C
    exp_q.push_back(16'hA53C);
    send_byte(8'hA5, 3, 1'b0);
    check("a5_state", 32'(dbg_state), 32'd1);
    repeat (1199) @(posedge clk);
    #1;
    check("a5_hold_cmd", 32'(cmd), 32'h0);
    check("a5_hold_cmd_rdy", 32'(cmd_rdy), 32'd0);
`ifdef CMD_CHKSUM_EN
    send_byte(8'h3C, 3, 1'b0);
    send_byte(8'h1E, 3, 1'b0);
`else
    send_byte(8'h3C, 3, 1'b0);
`endif
    check_cmd("a53c");
    check("a53c_accepts", 32'(accept_cnt), 32'(bytes_sent));
    check("a53c_no_err", 32'(err_cnt), 32'd0);

    // 12 then silence: exactly one err pulse at the timeout boundary
    send_byte(8'h12, 3, 1'b0);
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("tmo_before_err", 32'(err), 32'd0);
    check("tmo_before_state", 32'(dbg_state), 32'd1);
    @(posedge clk);
    #1;
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_state", 32'(dbg_state), 32'd0);
    check("tmo_cmd", 32'(cmd), 32'hA53C);
    check("tmo_cmd_rdy", 32'(cmd_rdy), 32'd1);
    @(posedge clk);
    #1;
    check("tmo_err_pulse", 32'(err), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("tmo_err_count", 32'(err_cnt), 32'd1);
    send_frame(8'h34, 8'h56, 1'b0);
    check_cmd("3456");

    // completion and acknowledge in the same cycle: set wins
    send_frame(8'h01, 8'h02, 1'b1);
    check_cmd("0102_set_wins");

    // plain acknowledge clears cmd_rdy, cmd kept
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    check("ack_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("ack_cmd", 32'(cmd), 32'h0102);

    // byte arriving on the last timeout cycle wins
    err0 = err_cnt;
    exp_q.push_back(16'h7788);
    send_byte(8'h77, 3, 1'b0);
    repeat (TMO - 1) @(posedge clk);
`ifdef CMD_CHKSUM_EN
    send_byte(8'h88, 3, 1'b0);
    repeat (TMO - 1) @(posedge clk);
    send_byte(8'h00, 3, 1'b0);
`else
    send_byte(8'h88, 3, 1'b0);
`endif
    check_cmd("7788_edge");
    repeat (3) @(posedge clk);
    #1;
    check("edge_no_err", 32'(err_cnt), 32'(err0));

`ifdef CMD_CHKSUM_EN
    send_frame(8'h10, 8'h20, 1'b0);
    check_cmd("1020_chk");
    err0 = err_cnt;
    send_byte(8'h10, 3, 1'b0);
    send_byte(8'h20, 3, 1'b0);
    send_byte(8'hCE, 3, 1'b0);
    check("bad_chk_err", 32'(err), 32'd1);
    check("bad_chk_cmd", 32'(cmd), 32'h1020);
    check("bad_chk_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("bad_chk_err_count", 32'(err_cnt), 32'(err0 + 1));
`endif

    // reset mid-frame discards without err
    err0 = err_cnt;
    send_byte(8'hFF, 3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_cmd", 32'(cmd), 32'h0);
    check("midrst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acc0 = accept_cnt;
    bytes_sent = 0;
    send_frame(8'h00, 8'h01, 1'b0);
    check_cmd("0001");
    check("midrst_no_err", 32'(err_cnt), 32'(err0));
    check("hold3_accepts", 32'(accept_cnt - acc0), 32'(bytes_sent));

    // random frames
    for (int k = 0; k < 4; k++) begin
      send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      check_cmd("rand");
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
